// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the pipeline skid-register slice.
//   - State encodings for the skid register (EMPTY / ONE / FULL). The codes
//     are chosen so that the state value is also the number of held entries.
//   - Default PC / instruction widths that together form the default payload.
//   - The NOP word presented while a stage holds nothing.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_PC_W    = 32;
    localparam int PIPE_INSTR_W = 32;
    localparam int PIPE_DATA_W  = PIPE_PC_W + PIPE_INSTR_W;

    localparam logic [63:0] NOP_WORD = 64'h0;

    // State codes double as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One storage slot: a valid flop plus a DATA_W payload register.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - capture load_data and mark the slot valid
//   clear      - empty the slot (payload returns to BUBBLE_VAL); wins over load
//   load_data  - payload to capture
//   valid      - slot holds an entry
//   data       - held payload, BUBBLE_VAL whenever the slot is empty
// -----------------------------------------------------------------------------
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = PIPE_DATA_W,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = DATA_W'(NOP_WORD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // Clearing also restores the bubble payload so an empty slot never
    // exposes stale data downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= BUBBLE_VAL;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= BUBBLE_VAL;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// Two-entry skid register between pipeline stages. Full throughput with
// in_ready coming straight from a flop, so no combinational path runs from
// out_ready back to in_ready.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   flush      - synchronous kill of all held entries (highest priority)
//   in_valid   - upstream presents in_data
//   in_ready   - stage can accept this cycle (skid slot empty)
//   in_data    - upstream payload
//   out_valid  - out_data holds a valid payload
//   out_ready  - downstream accepts out_data this cycle
//   out_data   - payload to downstream, BUBBLE_VAL when idle
//   occupancy  - number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = PIPE_DATA_W,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = DATA_W'(NOP_WORD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_din;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              skid_clear;

    logic              in_xfer;
    logic              out_xfer;

    pipe_slot #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
    ) u_main (
        .clk        (clk),
        .rst        (rst),
        .load       (main_load),
        .clear      (main_clear),
        .load_data  (main_din),
        .valid      (main_valid),
        .data       (main_data)
    );

    pipe_slot #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_data  (in_data),
        .valid      (skid_valid),
        .data       (skid_data)
    );

    // in_ready depends only on the skid flop; out_ready never reaches it.
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    // The state codes equal the entry count, so occupancy is a flop output.
    assign occupancy = state;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_valid & out_ready;

    // Slot control. Main always drives the output; skid only fills when
    // main is held and cannot drain, and refills main as soon as it does.
    // A downstream transfer during flush is simply absorbed by the flush.
    always_comb begin
        state_nxt  = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_din   = in_data;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
            state_nxt  = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer) begin
                        skid_load = 1'b1;
                        state_nxt = ST_FULL;
                    end else if (out_xfer) begin
                        main_clear = 1'b1;
                        state_nxt  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        main_load  = 1'b1;
                        main_din   = skid_data;
                        skid_clear = 1'b1;
                        state_nxt  = ST_ONE;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                    state_nxt  = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
// Directed checks of the skid register (streaming, backpressure, flush,
// asynchronous reset), a randomized valid/ready run against a queue model,
// and idle-payload checks on 32- and 96-bit instances with BUBBLE_VAL 0x13.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int DW = 64;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    // Parameter-sweep instances share clk/rst but have their own handshakes.
    logic          sw_valid;
    logic [31:0]   sw32_in_data;
    logic [95:0]   sw96_in_data;
    logic          sw32_in_ready, sw32_out_valid;
    logic          sw96_in_ready, sw96_out_valid;
    logic [31:0]   sw32_out_data;
    logic [95:0]   sw96_out_data;
    logic [1:0]    sw32_occ, sw96_occ;

    int            vectors;
    int            miscompares;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rnd_data;
    logic          rnd_valid;
    logic          rnd_ready;
    logic          in_acc;

    pipe_skid_reg #(.DATA_W(DW), .BUBBLE_VAL('0)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_skid_reg #(.DATA_W(32), .BUBBLE_VAL(32'h13)) u_sw32 (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .in_valid  (sw_valid),
        .in_ready  (sw32_in_ready),
        .in_data   (sw32_in_data),
        .out_valid (sw32_out_valid),
        .out_ready (1'b1),
        .out_data  (sw32_out_data),
        .occupancy (sw32_occ)
    );

    pipe_skid_reg #(.DATA_W(96), .BUBBLE_VAL(96'h13)) u_sw96 (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .in_valid  (sw_valid),
        .in_ready  (sw96_in_ready),
        .in_data   (sw96_in_data),
        .out_valid (sw96_out_valid),
        .out_ready (1'b1),
        .out_data  (sw96_out_data),
        .occupancy (sw96_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [127:0] got,
                                input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the rising edge.
    task automatic apply_stimulus(input logic v, input logic [DW-1:0] d,
                                  input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        sw_valid     = 1'b0;
        sw32_in_data = 32'hBEEF;
        sw96_in_data = 96'hABC;

        // Reset state, including the swept instances' idle payload.
        #12;
        check_output("rst_out_valid", 128'(out_valid), 128'(0));
        check_output("rst_occupancy", 128'(occupancy), 128'(0));
        check_output("rst_in_ready",  128'(in_ready),  128'(1));
        check_output("rst_out_data",  128'(out_data),  128'(0));
        check_output("sw32_idle",     128'(sw32_out_data), 128'h13);
        check_output("sw96_idle",     128'(sw96_out_data), 128'h13);

        @(negedge clk);
        rst = 1'b0;

        // Streaming with out_ready held high: 1-cycle latency, never above 1.
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(1'b1, DW'(i), 1'b1, 1'b0);
            check_output("stream_valid", 128'(out_valid), 128'(1));
            check_output("stream_data",  128'(out_data),  128'(i));
            check_output("stream_occ",   128'(occupancy), 128'(1));
        end
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("stream_drain_valid", 128'(out_valid), 128'(0));
        check_output("stream_drain_data",  128'(out_data),  128'(0));
        check_output("stream_drain_occ",   128'(occupancy), 128'(0));

        // Backpressure: A, B fill both slots; C waits upstream.
        apply_stimulus(1'b1, 64'hA, 1'b0, 1'b0);
        check_output("bp_occ1",   128'(occupancy), 128'(1));
        check_output("bp_data_a", 128'(out_data),  128'hA);
        apply_stimulus(1'b1, 64'hB, 1'b0, 1'b0);
        check_output("bp_occ2",   128'(occupancy), 128'(2));
        check_output("bp_ready0", 128'(in_ready),  128'(0));
        check_output("bp_hold_a", 128'(out_data),  128'hA);
        apply_stimulus(1'b1, 64'hC, 1'b0, 1'b0);
        check_output("bp_full_occ", 128'(occupancy), 128'(2));
        check_output("bp_full_a",   128'(out_data),  128'hA);
        apply_stimulus(1'b1, 64'hC, 1'b1, 1'b0);
        check_output("bp_data_b",  128'(out_data),  128'hB);
        check_output("bp_occ_b",   128'(occupancy), 128'(1));
        check_output("bp_ready_b", 128'(in_ready),  128'(1));
        apply_stimulus(1'b1, 64'hC, 1'b1, 1'b0);
        check_output("bp_data_c", 128'(out_data),  128'hC);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("bp_empty", 128'(occupancy), 128'(0));

        // Flush in FULL with a payload offered the same cycle.
        apply_stimulus(1'b1, 64'hA, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'hB, 1'b0, 1'b0);
        check_output("fl_pre_occ", 128'(occupancy), 128'(2));
        apply_stimulus(1'b1, 64'hC, 1'b0, 1'b1);
        check_output("fl_valid", 128'(out_valid), 128'(0));
        check_output("fl_data",  128'(out_data),  128'(0));
        check_output("fl_occ",   128'(occupancy), 128'(0));
        check_output("fl_ready", 128'(in_ready),  128'(1));
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0);
            check_output("fl_no_c", 128'(out_valid), 128'(0));
        end

        // Asynchronous reset between edges while FULL.
        apply_stimulus(1'b1, 64'h11, 1'b0, 1'b0);
        apply_stimulus(1'b1, 64'h22, 1'b0, 1'b0);
        check_output("ar_pre_occ", 128'(occupancy), 128'(2));
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_output("ar_valid", 128'(out_valid), 128'(0));
        check_output("ar_ready", 128'(in_ready),  128'(1));
        check_output("ar_occ",   128'(occupancy), 128'(0));
        check_output("ar_data",  128'(out_data),  128'(0));
        rst = 1'b0;
        apply_stimulus(1'b1, 64'h55, 1'b1, 1'b0);
        check_output("ar_first_valid", 128'(out_valid), 128'(1));
        check_output("ar_first_data",  128'(out_data),  128'h55);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        check_output("ar_drained", 128'(occupancy), 128'(0));

        // Random valid/ready against a FIFO model of held entries.
        exp_q.delete();
        for (int c = 0; c < 10000; c++) begin
            rnd_valid = ($urandom_range(0, 3) != 0);
            rnd_ready = 1'($urandom_range(0, 1));
            rnd_data  = {$urandom, $urandom};
            check_output("rnd_occ",   128'(occupancy), 128'(exp_q.size()));
            check_output("rnd_ready", 128'(in_ready),  128'(exp_q.size() < 2));
            check_output("rnd_valid", 128'(out_valid), 128'(exp_q.size() > 0));
            in_acc = rnd_valid && (exp_q.size() < 2);
            if (rnd_ready && exp_q.size() > 0) begin
                check_output("rnd_data", 128'(out_data), 128'(exp_q.pop_front()));
            end
            apply_stimulus(rnd_valid, rnd_data, rnd_ready, 1'b0);
            if (in_acc) begin
                exp_q.push_back(rnd_data);
            end
        end
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("rnd_flush_occ", 128'(occupancy), 128'(0));

        // Swept widths: a payload passes through, then idle shows 0x13.
        sw_valid = 1'b1;
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        check_output("sw32_data", 128'(sw32_out_data), 128'hBEEF);
        check_output("sw96_data", 128'(sw96_out_data), 128'hABC);
        sw_valid = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        check_output("sw32_idle_after", 128'(sw32_out_data), 128'h13);
        check_output("sw96_idle_after", 128'(sw96_out_data), 128'h13);
        check_output("sw32_valid_after", 128'(sw32_out_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 64, width of the payload carried per stage (e.g. next_pc concatenated with instruction).
REQ-002 Parameter BUBBLE_VAL, default 0, the payload value presented while the stage holds no valid entry (NOP).
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 flush  input  1  synchronous kill of all held entries.
REQ-006 in_valid  input  1  upstream presents a payload.
REQ-007 in_ready  output  1  stage can accept a payload this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid payload.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  DATA_W  payload to the downstream stage.
REQ-012 occupancy  output  2  number of held entries (0..2).

Function
REQ-013 Storage SHALL be two slots: main (drives out_*) and skid (overflow).
REQ-014 Upstream transfer SHALL occur when in_valid and in_ready are both 1; downstream transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015 in_ready SHALL equal NOT skid_valid, driven from a flop with no combinational path from out_ready.
REQ-016 Latency SHALL be 1 cycle from an accepted input to out_valid when the stage is empty; sustained throughput SHALL be 1 transfer per cycle while out_ready=1.
REQ-017 State SHALL follow EMPTY (occ 0), ONE (occ 1) and FULL (occ 2).
REQ-018 EMPTY: an accepted input SHALL load main and go to ONE.
REQ-019 ONE: input only SHALL load skid and go to FULL if out_ready=0; if out_ready=1, input SHALL load main and stay in ONE.
REQ-020 ONE: output only SHALL go to EMPTY; neither SHALL hold the state.
REQ-021 FULL: output accepted SHALL move skid to main and go to ONE; no input SHALL be accepted in FULL.
REQ-022 Ordering SHALL be strictly FIFO; no payload SHALL be duplicated or dropped except by flush.
REQ-023 When out_valid=0, out_data SHALL equal BUBBLE_VAL.
REQ-024 flush SHALL take priority over every transfer: next cycle occupancy=0, out_valid=0, in_ready=1, both slots=BUBBLE_VAL.
REQ-025 A payload presented in the same cycle as flush SHALL be discarded.
REQ-026 A downstream transfer in the same cycle as flush SHALL still count as consumed.
REQ-027 occupancy SHALL equal main_valid + skid_valid, registered.

Reset
REQ-028 While rst=1: out_valid=0, occupancy=0, in_ready=1, out_data=BUBBLE_VAL, skid data=BUBBLE_VAL, state EMPTY.
REQ-029 Assertion of rst mid-operation SHALL discard all held entries immediately, without waiting for a clock edge.
REQ-030 The first transfer after release SHALL be accepted on the first rising edge with rst=0.

Structure
REQ-031 Package pipe_pkg SHALL hold the state enum (EMPTY/ONE/FULL), the NOP word constant and the default PC/instruction widths used to form DATA_W.
REQ-032 One sub-module pipe_slot (valid flop plus DATA_W data register with load/clear) SHALL be instantiated twice, as main and skid.
REQ-033 No other hierarchy SHALL be used; total RTL SHALL fit within 120-400 lines.

Verification
REQ-034 Streaming: out_ready=1; in_data=0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later each, occupancy never exceeds 1.
REQ-035 Backpressure: send 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0; raise out_ready -> 0xA then 0xB in order; 0xC held upstream is not lost.
REQ-036 Flush in FULL: state FULL holding 0xA and 0xB; assert flush with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_data=0, occupancy=0; 0xC is never emitted.
REQ-037 Async reset mid-stream: assert rst between clock edges while occupancy=2 -> out_valid=0 and in_ready=1 immediately, before any edge.
REQ-038 Random valid/ready for 10k cycles against a scoreboard queue -> no loss, duplication or reordering; in_ready is independent of out_ready in the same cycle.
REQ-039 Parameter sweep with DATA_W=32 and 96 and BUBBLE_VAL=0x13 -> idle out_data equals 0x13 zero-extended to DATA_W.
